// File: rtl/grid_map_ram_pkg.sv
// Shared definitions for the occupancy-grid map: FSM states, default sizes
// and the meaning of stored cell values.
package grid_map_ram_pkg;

  localparam int unsigned COORD_W_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 2;

  localparam int unsigned EMPTY    = 0;
  localparam int unsigned WALL     = 1;
  localparam int unsigned VISITED  = 2;
  localparam int unsigned TREASURE = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/grid_dpram.sv
// Grid storage: one write port, two registered read ports (read-first).
// The array itself has no reset; only the read output registers do.
module grid_dpram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] wcur_o,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  input  logic              rzero_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;

  // Current contents at the write address, used for OR-merge by the parent.
  assign wcur_o = mem_q[waddr_i];

  // Single write port into the array.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered reads; same-edge writes are not yet visible (read-first).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else if (rzero_i) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= mem_q[raddr_a_i];
      rdata_b_q <= mem_q[raddr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/grid_map_ram.sv
// Occupancy-grid map: merge-capable writes, two read ports and a
// full-grid clear sweep that locks out writes and masks reads while busy.
module grid_map_ram
  import grid_map_ram_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  output logic               busy,
  output logic               done,
  input  logic               w_en,
  input  logic [COORD_W-1:0] w_x,
  input  logic [COORD_W-1:0] w_y,
  input  logic [DATA_W-1:0]  w_data,
  input  logic               w_mode,
  output logic               w_drop,
  input  logic [COORD_W-1:0] ra_x,
  input  logic [COORD_W-1:0] ra_y,
  input  logic [COORD_W-1:0] rb_x,
  input  logic [COORD_W-1:0] rb_y,
  output logic [DATA_W-1:0]  ra_data,
  output logic [DATA_W-1:0]  rb_data
);

  localparam int unsigned         ADDR_W    = 2 * COORD_W;
  localparam logic [ADDR_W-1:0]   LAST_ADDR = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_wcur;

  assign busy   = (state_q == ST_CLEAR);
  assign done   = done_q;
  assign w_drop = drop_q;

  // Next state, sweep counter and write-port steering.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = {w_y, w_x};
    mem_wdata = w_mode ? (mem_wcur | w_data) : w_data;
    unique case (state_q)
      ST_IDLE: begin
        mem_we = w_en;
        if (clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = DATA_W'(EMPTY);
        drop_d    = w_en;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  grid_dpram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i     (clk),
    .rst_i     (reset),
    .we_i      (mem_we),
    .waddr_i   (mem_waddr),
    .wdata_i   (mem_wdata),
    .wcur_o    (mem_wcur),
    .raddr_a_i ({ra_y, ra_x}),
    .raddr_b_i ({rb_y, rb_x}),
    .rzero_i   (busy),
    .rdata_a_o (ra_data),
    .rdata_b_o (rb_data)
  );

endmodule

// File: tb/tb_grid_map_ram.sv
// Self-checking bench for grid_map_ram: a cell-array model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_grid_map_ram;
  import grid_map_ram_pkg::*;

  localparam int CW    = 4;
  localparam int DW    = 2;
  localparam int CELLS = 1 << (2 * CW);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          busy, done, w_drop;
  logic          w_en = 1'b0;
  logic [CW-1:0] w_x = '0, w_y = '0;
  logic [DW-1:0] w_data = '0;
  logic          w_mode = 1'b0;
  logic [CW-1:0] ra_x = '0, ra_y = '0, rb_x = '0, rb_y = '0;
  logic [DW-1:0] ra_data, rb_data;

  int vectors = 0;
  int miscompares = 0;
  int busy_cyc = 0;
  int done_pulses = 0;

  // Model state: -1 marks a cell whose contents are not yet known.
  int m_mem [CELLS];
  bit m_busy = 1'b0;
  int m_left = 0;
  int m_done = 0, m_drop = 0, m_ra = 0, m_rb = 0;

  grid_map_ram #(
    .COORD_W (CW),
    .DATA_W  (DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .busy    (busy),
    .done    (done),
    .w_en    (w_en),
    .w_x     (w_x),
    .w_y     (w_y),
    .w_data  (w_data),
    .w_mode  (w_mode),
    .w_drop  (w_drop),
    .ra_x    (ra_x),
    .ra_y    (ra_y),
    .rb_x    (rb_x),
    .rb_y    (rb_y),
    .ra_data (ra_data),
    .rb_data (rb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial for (int i = 0; i < CELLS; i++) m_mem[i] = -1;

  // Behavioural model: read old contents, then apply the write or one sweep step.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_left = 0;
      m_done = 0; m_drop = 0; m_ra = 0; m_rb = 0;
    end else begin
      int wa;
      wa = int'(w_y) * (1 << CW) + int'(w_x);
      m_ra   = m_busy ? 0 : m_mem[int'(ra_y) * (1 << CW) + int'(ra_x)];
      m_rb   = m_busy ? 0 : m_mem[int'(rb_y) * (1 << CW) + int'(rb_x)];
      m_drop = (m_busy && w_en) ? 1 : 0;
      m_done = 0;
      if (m_busy) begin
        m_mem[CELLS - m_left] = 0;
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1;
        end
      end else begin
        if (w_en) begin
          if (w_mode && m_mem[wa] >= 0) m_mem[wa] = m_mem[wa] | int'(w_data);
          else if (w_mode)              m_mem[wa] = -1;
          else                          m_mem[wa] = int'(w_data);
        end
        if (clear) begin
          m_busy = 1'b1;
          m_left = CELLS;
        end
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("w_drop", 32'(w_drop), 32'(m_drop));
    if (m_ra >= 0) chk("ra_data", 32'(ra_data), 32'(m_ra));
    if (m_rb >= 0) chk("rb_data", 32'(rb_data), 32'(m_rb));
    if (busy) busy_cyc++;
    if (done) done_pulses++;
  end

  task automatic start_clear();
    clear = 1'b1;
    busy_cyc = 0;
    done_pulses = 0;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (done_pulses == 0 && n < max_cycles) begin
      tick();
      n++;
    end
    if (done_pulses == 0) chk("done_timeout", 32'd0, 32'd1);
    tick();
    tick();
  endtask

  task automatic wr(input int x, input int y, input int d, input bit mode);
    w_en = 1'b1; w_x = CW'(x); w_y = CW'(y); w_data = DW'(d); w_mode = mode;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_drop", 32'(w_drop), 32'd0);
    chk("rst_ra", 32'(ra_data), 32'd0);
    chk("rst_rb", 32'(rb_data), 32'd0);
    reset = 1'b0;
    tick();

    // Full clear: 256 busy cycles, one done pulse, cells read 0
    start_clear();
    wait_done(400);
    chk("sweep_len", 32'(busy_cyc), 32'd256);
    chk("sweep_done_cnt", 32'(done_pulses), 32'd1);
    ra_x = 0; ra_y = 0; rb_x = 15; rb_y = 15;
    tick();
    chk("rd_0_0", 32'(ra_data), 32'd0);
    chk("rd_15_15", 32'(rb_data), 32'd0);
    ra_x = 7; ra_y = 9;
    tick();
    chk("rd_7_9", 32'(ra_data), 32'd0);

    // Overwrite then OR-merge
    wr(3, 5, VISITED, 1'b0);
    tick();
    wr(3, 5, WALL, 1'b1);
    tick();
    w_en = 1'b0;
    ra_x = 3; ra_y = 5;
    tick();
    chk("or_merge", 32'(ra_data), 32'(TREASURE));

    // Same-edge read/write returns old value on both ports
    wr(4, 4, WALL, 1'b0);
    ra_x = 4; ra_y = 4; rb_x = 4; rb_y = 4;
    tick();
    w_en = 1'b0;
    chk("rf_old_a", 32'(ra_data), 32'd0);
    chk("rf_old_b", 32'(rb_data), 32'd0);
    tick();
    chk("rf_new_a", 32'(ra_data), 32'(WALL));
    chk("rf_new_b", 32'(rb_data), 32'(WALL));

    // Mid-sweep write and re-clear are ignored; reads masked
    ra_x = 3; ra_y = 5;
    start_clear();
    repeat (99) tick();
    wr(2, 2, TREASURE, 1'b0);
    clear = 1'b1;
    tick();
    w_en = 1'b0;
    clear = 1'b0;
    chk("mid_drop", 32'(w_drop), 32'd1);
    chk("mid_ra_zero", 32'(ra_data), 32'd0);
    wait_done(400);
    chk("mid_sweep_len", 32'(busy_cyc), 32'd256);
    chk("mid_done_cnt", 32'(done_pulses), 32'd1);
    ra_x = 2; ra_y = 2; rb_x = 3; rb_y = 5;
    tick();
    chk("mid_cell_2_2", 32'(ra_data), 32'd0);
    chk("mid_cell_3_5", 32'(rb_data), 32'd0);

    // clear and write on the same IDLE cycle: cell ends cleared
    wr(6, 6, VISITED, 1'b0);
    start_clear();
    w_en = 1'b0;
    wait_done(400);
    chk("cw_sweep_len", 32'(busy_cyc), 32'd256);
    ra_x = 6; ra_y = 6;
    tick();
    chk("cw_cell_6_6", 32'(ra_data), 32'd0);

    // Write a marker that the aborted sweep below will not reach
    wr(10, 12, TREASURE, 1'b0);
    tick();
    w_en = 1'b0;

    // Reset mid-sweep: immediate, no done pulse
    start_clear();
    repeat (50) tick();
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ra", 32'(ra_data), 32'd0);
    chk("abort_rb", 32'(rb_data), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    done_pulses = 0;
    repeat (300) tick();
    chk("abort_no_done", 32'(done_pulses), 32'd0);
    ra_x = 10; ra_y = 12;
    tick();
    chk("abort_kept", 32'(ra_data), 32'(TREASURE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
